// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch redirect logic.
package fetch_pkg;

  typedef enum logic {RUN, DRAIN} fetch_state_t;

  localparam int PC_STEP = 4;

  function automatic int cntWidth(input int flushCycles);
    return (flushCycles < 1) ? 1 : $clog2(flushCycles + 1);
  endfunction

endpackage

// File: rtl/fetch_redirect_unit_ifid_register.sv
// IF/ID pipeline register: clear inserts a bubble while holding the instruction,
// enable captures a new instruction, otherwise the contents hold.
module ifid_register #(
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [INSTR_WIDTH-1:0] instrIn,
  output logic [INSTR_WIDTH-1:0] instrFD,
  output logic                   validFD
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instrFD <= '0;
      validFD <= 1'b0;
    end else if (clear) begin
      validFD <= 1'b0;
    end else if (enable) begin
      instrFD <= instrIn;
      validFD <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch control: owns the PC, applies stalls and branch redirects, and drains
// the front end for FLUSH_CYCLES cycles after every accepted redirect.
module fetch_redirect_unit
  import fetch_pkg::*;
#(
  parameter int                PC_WIDTH     = 32,
  parameter int                INSTR_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int                FLUSH_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stopSignal,
  input  logic                   selectPCMux,
  input  logic [PC_WIDTH-1:0]    branchTarget,
  input  logic [INSTR_WIDTH-1:0] imemInstr,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [INSTR_WIDTH-1:0] instrFD,
  output logic                   validFD,
  output logic                   flushOut,
  output logic [15:0]            redirectCount
);

  localparam int CNT_W = cntWidth(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);

  fetch_state_t     state;
  logic [CNT_W-1:0] drainCnt;
  logic             ifidEnable;
  logic             ifidClear;

  // Redirect outranks a stall; DRAIN always produces bubbles.
  assign ifidClear  = selectPCMux || (state == DRAIN);
  assign ifidEnable = (state == RUN) && !stopSignal && !selectPCMux;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      pc            <= RESET_PC;
      drainCnt      <= '0;
      flushOut      <= 1'b0;
      redirectCount <= '0;
    end else if (selectPCMux) begin
      pc       <= branchTarget;
      state    <= DRAIN;
      drainCnt <= CNT_RELOAD;
      flushOut <= 1'b1;
      if (redirectCount != 16'hFFFF)
        redirectCount <= redirectCount + 16'd1;
    end else begin
      case (state)
        RUN: begin
          if (!stopSignal)
            pc <= pc + PC_WIDTH'(PC_STEP);
        end
        DRAIN: begin
          if (drainCnt == '0) begin
            state    <= RUN;
            flushOut <= 1'b0;
          end else begin
            drainCnt <= drainCnt - CNT_W'(1);
          end
        end
        default: begin
          state    <= RUN;
          flushOut <= 1'b0;
        end
      endcase
    end
  end

  ifid_register #(
    .INSTR_WIDTH(INSTR_WIDTH)
  ) uIfid (
    .clk     (clk),
    .rst     (rst),
    .enable  (ifidEnable),
    .clear   (ifidClear),
    .instrIn (imemInstr),
    .instrFD (instrFD),
    .validFD (validFD)
  );

endmodule

// File: doc/fetch_redirect_unit.md
# fetch_redirect_unit

Instruction-fetch control block that sits at the consumer end of the hazard unit's control-hazard signals. It owns the program counter and the IF/ID pipeline register. It performs stalls and branch redirects, and drains the front end with bubbles for a fixed number of cycles after each taken branch. It also keeps a running count of taken redirects for debug and performance readout.

## Interface
- PC_WIDTH, 32: program-counter width.
- INSTR_WIDTH, 32: instruction word width.
- RESET_PC, 0: PC value loaded on reset.
- FLUSH_CYCLES, 2: drain length after a redirect, in cycles; legal range ≥1.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stopSignal  in  1  stall/stop request from the hazard unit.
- selectPCMux  in  1  redirect request from the hazard unit; selects branchTarget as next PC.
- branchTarget  in  PC_WIDTH  redirect target; sampled only when selectPCMux=1.
- imemInstr  in  INSTR_WIDTH  instruction memory read data at address pc (combinational read).
- pc  out  PC_WIDTH  current fetch address.
- instrFD  out  INSTR_WIDTH  IF/ID instruction register.
- validFD  out  1  IF/ID valid bit; 0 = bubble.
- flushOut  out  1  kill signal to downstream stage registers; 1 while draining.
- redirectCount  out  16  number of accepted redirects, saturating.

## Operation
- States: RUN, DRAIN. Reset state is RUN.
- Reset values: pc=RESET_PC, instrFD=0, validFD=0, flushOut=0, redirectCount=0, drain counter=0.
- Redirect condition: selectPCMux=1, regardless of stopSignal. A redirect is accepted in both RUN and DRAIN.
- On a redirect at an edge, the block does all of the following:
  - pc ← branchTarget.
  - validFD ← 0; instrFD is held.
  - state ← DRAIN; counter ← FLUSH_CYCLES−1.
  - redirectCount increments, saturating at 0xFFFF.
- RUN with stopSignal=1 and selectPCMux=0 (stall): pc, instrFD and validFD all hold.
- RUN with no request:
  - instrFD ← imemInstr; validFD ← 1.
  - pc ← pc+4, modulo 2^PC_WIDTH, so 0xFFFFFFFC wraps to 0.
- DRAIN with no redirect:
  - pc holds at the target; validFD ← 0.
  - If counter==0, state ← RUN; otherwise counter decrements.
  - stopSignal is ignored; the drain length is fixed.
- DRAIN with a new redirect: target and counter reload, and the drain restarts from full length.
- flushOut is a registered output: it is 1 exactly when state==DRAIN.
- Priority order: rst > redirect > stall > normal advance.

## Timing
- A redirect sampled at edge N gives pc=target after edge N.
- flushOut=1 for exactly FLUSH_CYCLES cycles, from edge N to edge N+FLUSH_CYCLES.
- The target instruction appears in instrFD with validFD=1 after edge N+FLUSH_CYCLES+1; pc=target+4 at that same point.
- Branch penalty: FLUSH_CYCLES+1 bubbles in validFD.
- A stall has zero-cycle response: outputs are frozen at the edge where stopSignal=1 is sampled.
- Normal throughput: one instruction per cycle.
- Reset asserted mid-DRAIN: all outputs go to their reset values immediately (asynchronous), and fetch resumes in RUN from RESET_PC. The first valid instrFD appears at the first edge after rst deasserts.
- The redirectCount saturation and pc wrap-around both take effect on the same edge as the triggering event.

## Structure
- Shared package fetch_pkg contains:
  - typedef enum logic {RUN, DRAIN} fetch_state_t.
  - localparam PC_STEP = 4.
  - Counter width, derived as $clog2(FLUSH_CYCLES+1).
- One sub-module is natural: ifid_register. It holds instrFD/validFD with enable (hold) and clear (bubble) inputs and an async reset. The FSM, PC and counter live in the top module.

## Test plan
- Reset then free-run with imemInstr = pc value → pc 0,4,8,12…; instrFD tracks the previous pc; validFD=1 from the first edge after reset.
- stopSignal=1 for 3 cycles at pc=0x10 → pc and instrFD frozen for 3 cycles; advance resumes at 0x14.
- stopSignal=selectPCMux=1 with branchTarget=0x80 at pc=0x20, FLUSH_CYCLES=2:
  - pc=0x80 at the next edge; flushOut=1 for 2 cycles; validFD=0 for 3 cycles.
  - Then instrFD holds the instruction fetched at 0x80 with validFD=1; redirectCount=1.
- Second redirect (target 0x100) in the first DRAIN cycle → pc=0x100, drain restarts at full length, redirectCount=2.
- rst pulsed during DRAIN → immediate pc=RESET_PC, flushOut=0, validFD=0, redirectCount=0.
- Edge cases:
  - Preload redirectCount to 0xFFFF and redirect → count stays 0xFFFF.
  - pc=0xFFFFFFFC in RUN → wraps to 0.
